// File: rtl/free_list_pkg.sv
// Shared rename/commit constants used by the physical-register free list.
// Holds the architectural register count and the default tag/queue widths.
package rv32i_types;

    localparam int NUM_ARCH_REGS        = 32;
    localparam int PHYS_TAG_BITS        = 6;
    localparam int FREE_LIST_DEPTH_BITS = 5;

    // True when the set bits of m form one run starting at bit 0 (0000, 0001, 0011, ...).
    function automatic logic mask_contiguous(input logic [3:0] m);
        return (m & (m + 4'd1)) == 4'd0;
    endfunction

endpackage

// File: rtl/free_list.sv
// Circular free list of physical register tags: rename pops from head, commit pushes at tail.
// Flush makes every storage entry free again by moving head onto the new tail.
module free_list
    import rv32i_types::*;
#(
    parameter int PR_BITS       = PHYS_TAG_BITS,
    parameter int FL_DEPTH_BITS = FREE_LIST_DEPTH_BITS,
    parameter int NSIZE         = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NSIZE-1:0]                enqueue,
    input  logic [NSIZE-1:0][PR_BITS-1:0]   din,
    input  logic [NSIZE-1:0]                dequeue,
    output logic [NSIZE-1:0][PR_BITS-1:0]   dout,
    input  logic                            flush,
    output logic [FL_DEPTH_BITS:0]          elemcount,
    output logic [FL_DEPTH_BITS:0]          freespace
);

    localparam int                DEPTH   = 1 << FL_DEPTH_BITS;
    localparam int                PTR_W   = FL_DEPTH_BITS + 1;
    localparam logic [PTR_W-1:0]  DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0]  ONE_P   = PTR_W'(1);

    logic [PTR_W-1:0]          head_q, head_d;
    logic [PTR_W-1:0]          tail_q, tail_d;
    logic [PR_BITS-1:0]        mem_q [DEPTH];
    logic [PR_BITS-1:0]        mem_d [DEPTH];
    logic [NSIZE-1:0]          enq_ok;
    logic [PTR_W-1:0]          enq_cnt;
    logic [PTR_W-1:0]          deq_cnt;
    logic [FL_DEPTH_BITS-1:0]  widx [NSIZE];

    assign elemcount = tail_q - head_q;
    assign freespace = DEPTH_P - elemcount;

    genvar gi;
    generate
        for (gi = 0; gi < NSIZE; gi++) begin : g_port
            logic [PTR_W-1:0] rptr;
            logic [PTR_W-1:0] wptr;
            assign rptr     = head_q + PTR_W'(gi);
            assign wptr     = tail_q + PTR_W'(gi);
            assign widx[gi] = wptr[FL_DEPTH_BITS-1:0];
            assign dout[gi] = mem_q[rptr[FL_DEPTH_BITS-1:0]];
        end
    endgenerate

    // Grants use start-of-cycle counts, so a tag pushed this cycle cannot be popped until next cycle.
    always_comb begin
        enq_ok  = '0;
        enq_cnt = '0;
        deq_cnt = '0;
        for (int i = 0; i < NSIZE; i++) begin
            if (enqueue[i] && (PTR_W'(i) < freespace)) begin
                enq_ok[i] = 1'b1;
                enq_cnt   = enq_cnt + ONE_P;
            end
            if (dequeue[i] && !flush && (PTR_W'(i) < elemcount)) begin
                deq_cnt = deq_cnt + ONE_P;
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NSIZE; i++) begin
            if (enq_ok[i]) begin
                mem_d[widx[i]] = din[i];
            end
        end
    end

    always_comb begin
        tail_d = tail_q + enq_cnt;
        if (flush) begin
            head_d = {~tail_d[PTR_W-1], tail_d[PTR_W-2:0]};
        end else begin
            head_d = head_q + deq_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= DEPTH_P;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= PR_BITS'(NUM_ARCH_REGS + k);
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            mem_q  <= mem_d;
        end
    end

`ifndef SYNTHESIS
    // Overflow only warns: the excess pushes are dropped by design and recovery continues.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (mask_contiguous(4'(enqueue)))
                else $error("free_list: enqueue mask is not contiguous from bit 0");
            assert (mask_contiguous(4'(dequeue)))
                else $error("free_list: dequeue mask is not contiguous from bit 0");
            assert (PTR_W'($countones(enqueue)) <= freespace)
                else $warning("free_list: enqueue exceeds freespace, excess pushes dropped");
        end
    end
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list with two ports: vector table after reset, then
// hand sequences for drain/empty guard, wrap-around, overflow, flush and mid-run reset.
module tb_free_list;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       enqueue;
    logic [1:0][5:0]  din;
    logic [1:0]       dequeue;
    logic [1:0][5:0]  dout;
    logic             flush;
    logic [5:0]       elemcount;
    logic [5:0]       freespace;

    int n_cmp = 0;
    int n_bad = 0;
    logic [5:0] sb [$];

    free_list #(.PR_BITS(6), .FL_DEPTH_BITS(5), .NSIZE(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .enqueue   (enqueue),
        .din       (din),
        .dequeue   (dequeue),
        .dout      (dout),
        .flush     (flush),
        .elemcount (elemcount),
        .freespace (freespace)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] enq;
        logic [5:0] d0;
        logic [5:0] d1;
        logic [1:0] deq;
        int         e_cnt;
        int         e_d0;
        int         e_d1;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] e, input logic [5:0] a, input logic [5:0] b,
                       input logic [1:0] d, input logic f);
        enqueue = e;
        din[0]  = a;
        din[1]  = b;
        dequeue = d;
        flush   = f;
        @(posedge clk);
        #1;
        enqueue = '0;
        dequeue = '0;
        flush   = 1'b0;
    endtask

    task automatic pop_n(input int n);
        int h;
        h = (n < sb.size()) ? n : sb.size();
        if (sb.size() > 0) chk("pop_dout0", int'(dout[0]), int'(sb[0]));
        if (h == 2) chk("pop_dout1", int'(dout[1]), int'(sb[1]));
        cyc(2'b00, 6'd0, 6'd0, (n == 2) ? 2'b11 : 2'b01, 1'b0);
        repeat (h) void'(sb.pop_front());
        chk("pop_count", int'(elemcount), sb.size());
    endtask

    task automatic push_n(input logic [5:0] a, input logic [5:0] b, input int n);
        cyc((n == 2) ? 2'b11 : 2'b01, a, b, 2'b00, 1'b0);
        sb.push_back(a);
        if (n == 2) sb.push_back(b);
        chk("push_count", int'(elemcount), sb.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        enqueue = '0;
        din     = '0;
        dequeue = '0;
        flush   = 1'b0;

        vecs[0] = '{2'b00, 6'd0,  6'd0,  2'b11, 30, 34, 35};
        vecs[1] = '{2'b00, 6'd0,  6'd0,  2'b11, 28, 36, 37};
        vecs[2] = '{2'b00, 6'd0,  6'd0,  2'b11, 26, 38, 39};
        vecs[3] = '{2'b00, 6'd0,  6'd0,  2'b11, 24, 40, 41};
        vecs[4] = '{2'b01, 6'd5,  6'd0,  2'b01, 24, 41, 42};
        vecs[5] = '{2'b11, 6'd10, 6'd11, 2'b00, 26, 41, 42};
        vecs[6] = '{2'b00, 6'd0,  6'd0,  2'b00, 26, 41, 42};
        vecs[7] = '{2'b00, 6'd0,  6'd0,  2'b01, 25, 42, 43};

        // Reset state, then confirm activity during reset is ignored.
        #2 rst = 1'b1;
        #1;
        chk("rst_dout0", int'(dout[0]), 32);
        chk("rst_dout1", int'(dout[1]), 33);
        chk("rst_count", int'(elemcount), 32);
        chk("rst_free",  int'(freespace), 0);
        enqueue = 2'b11; din[0] = 6'd1; din[1] = 6'd2; dequeue = 2'b11; flush = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_count", int'(elemcount), 32);
        chk("rst_hold_dout0", int'(dout[0]), 32);
        enqueue = '0; dequeue = '0; flush = 1'b0;
        rst = 1'b0;
        $display("reset: count=%0d dout0=%0d dout1=%0d", elemcount, dout[0], dout[1]);

        // Table: pops after reset, then push/pop in the same cycle.
        for (int v = 0; v < 8; v++) begin
            cyc(vecs[v].enq, vecs[v].d0, vecs[v].d1, vecs[v].deq, 1'b0);
            chk("vec_count", int'(elemcount), vecs[v].e_cnt);
            chk("vec_free",  int'(freespace), 32 - vecs[v].e_cnt);
            chk("vec_dout0", int'(dout[0]), vecs[v].e_d0);
            chk("vec_dout1", int'(dout[1]), vecs[v].e_d1);
            $display("vec %0d: count=%0d dout0=%0d dout1=%0d", v, elemcount, dout[0], dout[1]);
        end

        // Drain in FIFO order; tag 5 comes out after the reset tags, then 10, 11.
        for (int t = 42; t < 64; t++) sb.push_back(6'(t));
        sb.push_back(6'd5);
        sb.push_back(6'd10);
        sb.push_back(6'd11);
        while (sb.size() > 0) pop_n(2);
        chk("empty_count", int'(elemcount), 0);
        cyc(2'b00, 6'd0, 6'd0, 2'b11, 1'b0);
        chk("empty_guard_count", int'(elemcount), 0);
        chk("empty_guard_free",  int'(freespace), 32);
        $display("drain: count=%0d free=%0d", elemcount, freespace);

        // Wrap-around: 5 queued, then 40 push/pop pairs move both pointers past entry 31.
        push_n(6'd1, 6'd2, 2);
        push_n(6'd3, 6'd4, 2);
        push_n(6'd5, 6'd0, 1);
        for (int i = 0; i < 40; i++) begin
            chk("wrap_dout0", int'(dout[0]), int'(sb[0]));
            cyc(2'b01, 6'(6 + i), 6'd0, 2'b01, 1'b0);
            void'(sb.pop_front());
            sb.push_back(6'(6 + i));
        end
        chk("wrap_count", int'(elemcount), 5);
        while (sb.size() > 0) pop_n(1);
        $display("wrap: count=%0d", elemcount);

        // Overflow: at freespace 1 only din[0] lands.
        for (int j = 0; j < 15; j++) push_n(6'(10 + 2 * j), 6'(11 + 2 * j), 2);
        push_n(6'd40, 6'd0, 1);
        chk("ovf_pre_free", int'(freespace), 1);
        cyc(2'b11, 6'd62, 6'd63, 2'b00, 1'b0);
        sb.push_back(6'd62);
        chk("ovf_count", int'(elemcount), 32);
        chk("ovf_free",  int'(freespace), 0);
        while (sb.size() > 0) pop_n(2);
        chk("ovf_drained", int'(elemcount), 0);
        $display("overflow: count=%0d", elemcount);

        // Flush at count 20 with a same-cycle push of 7: list reads full, 7 is last.
        for (int j = 0; j < 10; j++) push_n(6'(2 * j), 6'(2 * j + 1), 2);
        chk("flush_pre_count", int'(elemcount), 20);
        cyc(2'b01, 6'd7, 6'd0, 2'b11, 1'b1);
        sb.delete();
        chk("flush_count", int'(elemcount), 32);
        chk("flush_free",  int'(freespace), 0);
        repeat (15) cyc(2'b00, 6'd0, 6'd0, 2'b11, 1'b0);
        cyc(2'b00, 6'd0, 6'd0, 2'b01, 1'b0);
        chk("flush_last_count", int'(elemcount), 1);
        chk("flush_last_tag",   int'(dout[0]), 7);
        $display("flush: count=%0d last=%0d", elemcount, dout[0]);

        // Reset in the middle of a push discards it and reloads the initial tags.
        enqueue = 2'b11; din[0] = 6'd20; din[1] = 6'd21;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_count", int'(elemcount), 32);
        chk("midrst_free",  int'(freespace), 0);
        chk("midrst_dout0", int'(dout[0]), 32);
        chk("midrst_dout1", int'(dout[1]), 33);
        enqueue = '0;
        rst = 1'b0;
        cyc(2'b00, 6'd0, 6'd0, 2'b01, 1'b0);
        chk("midrst_pop_dout0", int'(dout[0]), 33);
        chk("midrst_pop_count", int'(elemcount), 31);
        $display("midrst: count=%0d dout0=%0d", elemcount, dout[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
